// File: rtl/double_pkg.sv
// Shared binary64 definitions used by the double<->integer converters.
package double_pkg;

  localparam int EXP_BIAS = 1023;
  localparam int FRAC_W   = 52;
  localparam int EXP_W    = 11;
  localparam int SIG_W    = FRAC_W + 1;
  localparam int INT_W    = 64;

  localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;

  // Biased exponent landmarks used by the double-to-int classifier.
  localparam logic [EXP_W-1:0] EXP_SPECIAL    = 11'd2047;  // NaN / infinity
  localparam logic [EXP_W-1:0] EXP_ONE        = 11'd1023;  // 1.0 <= |x|
  localparam logic [EXP_W-1:0] EXP_SHIFT_ZERO = 11'd1075;  // 2^52: significand is already an integer
  localparam logic [EXP_W-1:0] EXP_INT_LIMIT  = 11'd1086;  // 2^63: first magnitude outside int64

  // Unpacked double; significand carries the hidden bit at [52].
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] significand;
  } unpacked_double_t;

  // Result category decided in the classification stage.
  typedef enum logic [1:0] {
    CLS_NUMBER  = 2'd0,  // ordinary in-range value, goes through the shifter
    CLS_SMALL   = 2'd1,  // |x| < 1, zero or denormal: result is zero
    CLS_INVALID = 2'd2   // NaN, infinity or out of int64 range
  } d2i_class_t;

  // Split a raw binary64 word into sign, exponent and significand with hidden bit.
  function automatic unpacked_double_t unpack_double(input logic [63:0] a);
    unpacked_double_t u;
    u.sign        = a[63];
    u.exp         = a[62:52];
    u.significand = {(a[62:52] != 11'd0), a[51:0]};
    return u;
  endfunction

endpackage

// File: rtl/double_to_int_shift.sv
// Combinational 53-to-64-bit bidirectional shifter. Left shifts scale an
// integer-valued significand up; right shifts truncate toward zero and report
// any discarded one-bits through sticky.
module double_to_int_shift
  import double_pkg::*;
(
  input  logic [SIG_W-1:0] sig,
  input  logic             shift_left,
  input  logic [5:0]       shift_amt,
  output logic [INT_W-1:0] mag,
  output logic             sticky
);

  logic [INT_W-1:0] wide;
  logic [SIG_W-1:0] lost_mask;

  // Select shift direction; only right shifts can lose fraction bits.
  always_comb begin
    wide      = {11'd0, sig};
    lost_mask = ~({SIG_W{1'b1}} << shift_amt);
    if (shift_left) begin
      mag    = wide << shift_amt;
      sticky = 1'b0;
    end else begin
      mag    = wide >> shift_amt;
      sticky = |(sig & lost_mask);
    end
  end

endmodule

// File: rtl/double_to_int.sv
// Four-stage binary64 to int64 converter, round toward zero, with invalid and
// inexact flags. No backpressure: one operand per cycle, fixed latency.
module double_to_int
  import double_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] input_a,
  input  logic        input_a_stb,
  output logic [63:0] output_z,
  output logic        output_z_stb,
  output logic        output_z_invalid,
  output logic        output_z_inexact
);

  // ---------------- S1: operand capture ----------------
  logic [63:0] s1_a;
  logic        s1_stb;

  // Register the raw operand and its valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= 64'd0;
      s1_stb <= 1'b0;
    end else begin
      s1_a   <= input_a;
      s1_stb <= input_a_stb;
    end
  end

  // ---------------- S2: classification ----------------
  unpacked_double_t s1_u;
  d2i_class_t       cls;
  logic             cls_left;
  logic [5:0]       cls_amt;
  logic             cls_small_inexact;
  logic             cls_is_min;
  logic [EXP_W-1:0] left_dist;
  logic [EXP_W-1:0] right_dist;

  assign s1_u       = unpack_double(s1_a);
  assign left_dist  = s1_u.exp - EXP_SHIFT_ZERO;
  assign right_dist = EXP_SHIFT_ZERO - s1_u.exp;
  // -2^63 is the one magnitude at the range limit that still fits int64.
  assign cls_is_min = s1_u.sign && (s1_u.exp == EXP_INT_LIMIT) &&
                      (s1_u.significand[FRAC_W-1:0] == 52'd0);

  // Decide the result category and the shift needed to align the binary point.
  always_comb begin
    cls               = CLS_NUMBER;
    cls_left          = 1'b0;
    cls_amt           = 6'd0;
    cls_small_inexact = 1'b0;
    if (s1_u.exp == EXP_SPECIAL) begin
      cls = CLS_INVALID;
    end else if ((s1_u.exp >= EXP_INT_LIMIT) && !cls_is_min) begin
      cls = CLS_INVALID;
    end else if (s1_u.exp < EXP_ONE) begin
      // -0.0 and +0.0 have no set bits, so they stay exact.
      cls               = CLS_SMALL;
      cls_small_inexact = (s1_u.exp != 11'd0) || (s1_u.significand[FRAC_W-1:0] != 52'd0);
    end else if (s1_u.exp >= EXP_SHIFT_ZERO) begin
      cls      = CLS_NUMBER;
      cls_left = 1'b1;
      cls_amt  = left_dist[5:0];   // 0..11
    end else begin
      cls      = CLS_NUMBER;
      cls_left = 1'b0;
      cls_amt  = right_dist[5:0];  // 1..52
    end
  end

  logic             s2_stb;
  logic             s2_sign;
  d2i_class_t       s2_cls;
  logic [SIG_W-1:0] s2_sig;
  logic             s2_left;
  logic [5:0]       s2_amt;
  logic             s2_small_inexact;

  // Register the classification result and shift control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_stb           <= 1'b0;
      s2_sign          <= 1'b0;
      s2_cls           <= CLS_SMALL;
      s2_sig           <= 53'd0;
      s2_left          <= 1'b0;
      s2_amt           <= 6'd0;
      s2_small_inexact <= 1'b0;
    end else begin
      s2_stb           <= s1_stb;
      s2_sign          <= s1_u.sign;
      s2_cls           <= cls;
      s2_sig           <= s1_u.significand;
      s2_left          <= cls_left;
      s2_amt           <= cls_amt;
      s2_small_inexact <= cls_small_inexact;
    end
  end

  // ---------------- S3: shift and sticky ----------------
  logic [INT_W-1:0] shift_mag;
  logic             shift_sticky;
  logic             s3_inexact_next;

  double_to_int_shift u_shift (
    .sig        (s2_sig),
    .shift_left (s2_left),
    .shift_amt  (s2_amt),
    .mag        (shift_mag),
    .sticky     (shift_sticky)
  );

  // Pick which inexact source applies to this result category.
  always_comb begin
    s3_inexact_next = 1'b0;
    case (s2_cls)
      CLS_NUMBER:  s3_inexact_next = shift_sticky;
      CLS_SMALL:   s3_inexact_next = s2_small_inexact;
      CLS_INVALID: s3_inexact_next = 1'b0;
      default:     s3_inexact_next = 1'b0;
    endcase
  end

  logic             s3_stb;
  logic             s3_sign;
  d2i_class_t       s3_cls;
  logic [INT_W-1:0] s3_mag;
  logic             s3_inexact;

  // Register the aligned magnitude and its exactness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_stb     <= 1'b0;
      s3_sign    <= 1'b0;
      s3_cls     <= CLS_SMALL;
      s3_mag     <= 64'd0;
      s3_inexact <= 1'b0;
    end else begin
      s3_stb     <= s2_stb;
      s3_sign    <= s2_sign;
      s3_cls     <= s2_cls;
      s3_mag     <= shift_mag;
      s3_inexact <= s3_inexact_next;
    end
  end

  // ---------------- S4: sign apply and output ----------------
  logic [INT_W-1:0] z_next;
  logic             invalid_next;
  logic             inexact_next;

  // Apply the sign and substitute the saturation pattern for invalid inputs.
  always_comb begin
    z_next       = 64'd0;
    invalid_next = 1'b0;
    inexact_next = 1'b0;
    case (s3_cls)
      CLS_NUMBER: begin
        // Negating 2^63 wraps to INT64_MIN, which is the correct -2^63 result.
        if (s3_sign) begin
          z_next = 64'd0 - s3_mag;
        end else begin
          z_next = s3_mag;
        end
        inexact_next = s3_inexact;
      end
      CLS_SMALL: begin
        z_next       = 64'd0;
        inexact_next = s3_inexact;
      end
      CLS_INVALID: begin
        z_next       = INT64_MIN;
        invalid_next = 1'b1;
      end
      default: begin
        z_next       = INT64_MIN;
        invalid_next = 1'b1;
      end
    endcase
  end

  // Register all outputs so nothing reaches the ports combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_z         <= 64'd0;
      output_z_stb     <= 1'b0;
      output_z_invalid <= 1'b0;
      output_z_inexact <= 1'b0;
    end else begin
      output_z         <= z_next;
      output_z_stb     <= s3_stb;
      output_z_invalid <= invalid_next;
      output_z_inexact <= inexact_next;
    end
  end

endmodule

// File: tb/tb_double_to_int.sv
// Directed and short random stimulus for double_to_int with a scoreboard queue.
module tb_double_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] input_a = 64'd0;
  logic        input_a_stb = 1'b0;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_invalid;
  logic        output_z_inexact;

  double_to_int dut (
    .clk              (clk),
    .rst              (rst),
    .input_a          (input_a),
    .input_a_stb      (input_a_stb),
    .output_z         (output_z),
    .output_z_stb     (output_z_stb),
    .output_z_invalid (output_z_invalid),
    .output_z_inexact (output_z_inexact)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] a;
    logic        stb;
    logic [63:0] z;
    logic        inv;
    logic        inex;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  // Reference: value = m * 2^(e-1075), held as 128-bit fixed point with 64 fraction bits.
  function automatic void model(input logic [63:0] a, output logic [63:0] z,
                                output logic inv, output logic inex);
    logic          s;
    logic [10:0]   e;
    logic [51:0]   f;
    logic [127:0]  fx;
    logic [63:0]   mag;
    s = a[63]; e = a[62:52]; f = a[51:0];
    z = 64'd0; inv = 1'b0; inex = 1'b0;
    if (e == 11'h7FF) begin
      z = MIN64; inv = 1'b1;
    end else if (s && a[62:0] == 63'h43E0_0000_0000_0000) begin
      z = MIN64;
    end else if (e >= 11'd1086) begin
      z = MIN64; inv = 1'b1;
    end else if (e < 11'd1023) begin
      inex = (a[62:0] != 63'd0);
    end else begin
      fx   = {75'd0, 1'b1, f} << (int'(e) - 1011);
      mag  = fx[127:64];
      inex = (fx[63:0] != 64'd0);
      z    = s ? (64'd0 - mag) : mag;
    end
  endfunction

  task automatic cmp64(input string name, input logic [63:0] op,
                       input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s op=%h: observed %h expected %h", name, op, obs, expv);
    end
  endtask

  task automatic cmp1(input string name, input logic [63:0] op,
                      input logic obs, input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s op=%h: observed %b expected %b", name, op, obs, expv);
    end
  endtask

  // Compare the outputs against whatever the scoreboard says is due this cycle.
  task automatic check_outputs();
    exp_t r;
    if (q.size() > 0 && q[0].cyc == cyc - 3) begin
      r = q.pop_front();
      cmp1("stb", r.a, output_z_stb, r.stb);
      if (r.stb) begin
        cmp64("z", r.a, output_z, r.z);
        cmp1("invalid", r.a, output_z_invalid, r.inv);
        cmp1("inexact", r.a, output_z_inexact, r.inex);
      end
    end else begin
      cmp1("idle_stb", 64'd0, output_z_stb, 1'b0);
    end
  endtask

  // One clock: optionally record the sampled operand, then check at the falling edge.
  task automatic tick(input logic record);
    exp_t r;
    @(posedge clk);
    cyc++;
    if (record) begin
      r.cyc = cyc;
      r.a   = input_a;
      r.stb = input_a_stb;
      model(input_a, r.z, r.inv, r.inex);
      q.push_back(r);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step(input logic [63:0] a, input logic stb);
    input_a     = a;
    input_a_stb = stb;
    tick(1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    cmp1({name, "_stb"}, 64'd0, output_z_stb, 1'b0);
    cmp64({name, "_z"}, 64'd0, output_z, 64'd0);
    cmp1({name, "_invalid"}, 64'd0, output_z_invalid, 1'b0);
    cmp1({name, "_inexact"}, 64'd0, output_z_inexact, 1'b0);
  endtask

  logic [9:0]  pat;
  logic [63:0] rnd;

  initial begin
    // Asynchronous reset at start, checked before any clock edge.
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset0");
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    tick(1'b0);
    step(64'd0, 1'b0);
    step(64'd0, 1'b0);

    // Directed values, each isolated by idle cycles so stb width is visible.
    step(64'h3FF0_0000_0000_0000, 1'b1);   // 1.0
    step(64'd0, 1'b0);
    step(64'd0, 1'b0);
    step(64'd0, 1'b0);
    step(64'd0, 1'b0);
    step(64'hC004_0000_0000_0000, 1'b1);   // -2.5
    step(64'h3FE0_0000_0000_0000, 1'b1);   // 0.5
    step(64'h0000_0000_0000_0001, 1'b1);   // denormal
    step(64'h8000_0000_0000_0000, 1'b1);   // -0.0
    step(64'h43DF_FFFF_FFFF_FFFF, 1'b1);   // largest below 2^63
    step(64'h43E0_0000_0000_0000, 1'b1);   // 2^63
    step(64'hC3E0_0000_0000_0000, 1'b1);   // -2^63
    step(64'h7FF8_0000_0000_0000, 1'b1);   // NaN
    step(64'hFFF0_0000_0000_0000, 1'b1);   // -inf
    step(64'h4330_0000_0000_0001, 1'b1);   // 2^52+1, shift 0
    step(64'hC3E0_0000_0000_0001, 1'b1);   // just below -2^63
    step(64'd0, 1'b0);

    // Random stream with stb pattern 1101110111.
    pat = 10'b1101110111;
    for (int i = 0; i < 10; i++) begin
      rnd = {$urandom(), $urandom()};
      rnd[62:52] = 11'($urandom_range(1000, 1090));
      step(rnd, pat[9-i]);
    end
    for (int i = 0; i < 4; i++) step(64'd0, 1'b0);

    // Reset mid-stream: outputs clear at once, in-flight operands vanish.
    step(64'hC004_0000_0000_0000, 1'b1);
    step(64'h4059_0000_0000_0000, 1'b1);   // 100.0
    step(64'h4024_0000_0000_0000, 1'b1);   // 10.0
    step(64'hBFF0_0000_0000_0000, 1'b1);   // -1.0
    input_a_stb = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_mid");
    q.delete();
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    step(64'h4000_0000_0000_0000, 1'b1);   // 2.0, first after reset
    step(64'd0, 1'b0);
    for (int i = 0; i < 5; i++) step(64'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/double_to_int.md
# double_to_int

Pipelined converter from IEEE-754 binary64 to a signed 64-bit two's-complement integer, rounding toward zero. It is the inverse-direction companion of the integer-to-double converter in the components library and is used wherever a double result must return to the integer datapath. The block accepts one operand per cycle with no backpressure and produces a fixed-latency result with invalid and inexact flags.

## Interface
Parameters: none; all widths are fixed by binary64 and int64.

- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- input_a  in  64  binary64 operand
- input_a_stb  in  1  operand valid; sampled every rising edge
- output_z  out  64  signed int64 result
- output_z_stb  out  1  result valid
- output_z_invalid  out  1  operand was NaN, ±inf or out of int64 range
- output_z_inexact  out  1  nonzero fraction bits were discarded

## Operation
- Unpacking: s = a[63], e = a[62:52], f = a[51:0]; significand m = {e!=0, f} (53 bits).
- Classification, in priority order:
  - e == 2047 (NaN, ±inf): z = 64'h8000_0000_0000_0000, invalid = 1, inexact = 0.
  - e >= 1086, except exactly -2^63 (s=1, e=1086, f=0): z = 64'h8000_0000_0000_0000, invalid = 1, inexact = 0.
  - e < 1023, covering zero, denormals and |x| < 1: z = 0, invalid = 0, inexact = (e!=0 || f!=0). -0.0 gives 0 with inexact = 0.
  - Otherwise: if e >= 1075, mag = m << (e-1075), with shift 0..11. If e < 1075, mag = m >> (1075-e), with shift 1..52, and inexact = OR of the shifted-out bits. z = s ? -mag : mag, computed in 64 bits.
- -2^63 exact: mag = 2^63, and negation yields 64'h8000_0000_0000_0000 with invalid = 0.
- The pipeline has no stall and no backpressure. output_z_stb is input_a_stb delayed through the pipeline. Data with stb = 0 still propagates, but its outputs are don't-care.

## Timing
- There are four register stages:
  - S1: register the operand and stb.
  - S2: classify and compute the shift amount.
  - S3: shift and compute the sticky bit.
  - S4: conditional negate, then register the outputs.
- Latency: an operand sampled at edge N drives all outputs from just after edge N+3 until edge N+4.
- Throughput is one operand per cycle. Back-to-back operands produce back-to-back results in the same order, and gaps in input_a_stb reproduce identically on output_z_stb.
- Reset clears every stage's stb, output_z, output_z_invalid and output_z_inexact to 0 immediately, without waiting for a clock.
- Operands in flight when rst asserts are discarded and never appear.
- After rst deasserts, output_z_stb stays 0 until an operand sampled after deassertion reaches S4, i.e. at the earliest 3 edges later.
- All outputs are driven directly from S4 flops; there is no combinational path from input to output.

## Structure
- Shared package double_pkg holds:
  - EXP_BIAS = 1023, FRAC_W = 52, EXP_W = 11.
  - INT64_MIN = 64'h8000_0000_0000_0000.
  - The unpacked-double typedef {sign, exp, significand}, reused by int_to_double.
- One sub-module, double_to_int_shift: combinational 53-to-64-bit bidirectional shifter with a sticky-OR output, instanced in S3.
- Pipeline registers and classification stay in the top module.

## Test plan
- 0x3FF0_0000_0000_0000 (1.0) at edge N -> z = 1, invalid = 0, inexact = 0, stb high just after edge N+3 only.
- 0xC004_0000_0000_0000 (-2.5) -> z = 0xFFFF_FFFF_FFFF_FFFE, inexact = 1.
- 0x3FE0_0000_0000_0000 (0.5) -> z = 0, inexact = 1.
- 0x0000_0000_0000_0001 (denormal) -> z = 0, inexact = 1.
- 0x8000_0000_0000_0000 (-0.0) -> z = 0, inexact = 0.
- Range edges:
  - 0x43DF_FFFF_FFFF_FFFF -> z = 0x7FFF_FFFF_FFFF_FC00, flags 0.
  - 0x43E0_0000_0000_0000 (2^63) -> z = INT64_MIN, invalid = 1.
  - 0xC3E0_0000_0000_0000 (-2^63) -> z = INT64_MIN, invalid = 0.
- Specials: 0x7FF8_0000_0000_0000 (NaN) and 0xFFF0_0000_0000_0000 (-inf) -> z = INT64_MIN, invalid = 1, inexact = 0.
- Stream and reset, two parts:
  - 10 back-to-back random operands with stb pattern 1101110111 -> identical pattern and values, each delayed 3 edges.
  - rst pulsed mid-stream -> outputs go to 0 asynchronously, no pre-reset result emerges, and the first post-reset result appears 3 edges after its sampling edge.
